// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access pipeline stage.
// Exports: control bit indices, FSM state enum, full-word byte-enable value.
package mem_stage_pkg;

    localparam int CTL_RD   = 0;
    localparam int CTL_WR   = 1;
    localparam int CTL_RW   = 2;
    localparam int CTL_BYTE = 3;

    localparam logic [3:0] BE_WORD = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store replication, byte enables, load byte extract.
// Ports: byte_acc/lane select mode; store_data/load_word in; lanes out.
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic        byte_acc,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] store_lanes,
    output logic [3:0]  byte_en,
    output logic [31:0] load_data
);

    always_comb begin
        store_lanes = store_data;
        byte_en     = BE_WORD;
        load_data   = load_word;
        if (byte_acc) begin
            store_lanes = {4{store_data[7:0]}};
            byte_en     = 4'b0001 << lane;
            unique case (lane)
                2'd0: load_data = {24'b0, load_word[7:0]};
                2'd1: load_data = {24'b0, load_word[15:8]};
                2'd2: load_data = {24'b0, load_word[23:16]};
                2'd3: load_data = {24'b0, load_word[31:24]};
                default: load_data = load_word;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/M in, req/ack data memory, M/WB results out.
// Ports: clk, reset (async low), EX/M inputs, stall, mem_* bus, wb_*, mem_err.
// Build option: MEM_STAGE_BYTE_EN enables byte accesses and alignment checks.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] address_in,
    input  logic [31:0] data_in,
    input  logic [3:0]  control_in,
    input  logic [4:0]  rgD_index_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        mem_err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic        is_rd;
    logic        is_wr;
    logic        is_mem;
    logic        byte_acc;
    logic        misalign;
    logic        illegal;
    logic        accept;
    logic        timed_out;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic [3:0]  al_be;

    assign is_rd  = control_in[CTL_RD];
    assign is_wr  = control_in[CTL_WR];
    assign is_mem = is_rd | is_wr;

`ifdef MEM_STAGE_BYTE_EN
    assign byte_acc = control_in[CTL_BYTE];
    assign misalign = !byte_acc && (address_in[1:0] != 2'b00);
`else
    logic unused_byte_ctl;
    assign unused_byte_ctl = control_in[CTL_BYTE];
    assign byte_acc = 1'b0;
    assign misalign = 1'b0;
`endif

    assign illegal   = (is_rd && is_wr) || (is_mem && misalign);
    assign accept    = valid_in && is_mem && !illegal;
    assign timed_out = (cnt == CW'(TIMEOUT - 1));

    mem_lane_align u_align (
        .byte_acc    (byte_acc),
        .lane        (address_in[1:0]),
        .store_data  (data_in),
        .load_word   (mem_rdata),
        .store_lanes (al_wdata),
        .byte_en     (al_be),
        .load_data   (al_rdata)
    );

    // Gated by reset so an aborted access releases the pipeline at once.
    always_comb begin
        stall = 1'b0;
        if (reset) begin
            case (state)
                IDLE:    stall = accept;
                BUSY:    stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    wb_valid <= 1'b0;
                    if (valid_in) begin
                        if (illegal) begin
                            wb_valid     <= 1'b1;
                            wb_data      <= address_in;
                            wb_rd        <= rgD_index_in;
                            wb_reg_write <= 1'b0;
                            mem_err      <= 1'b1;
                        end else if (is_mem) begin
                            mem_req   <= 1'b1;
                            mem_we    <= is_wr;
                            mem_addr  <= {address_in[31:2], 2'b00};
                            mem_wdata <= al_wdata;
                            mem_be    <= al_be;
                            cnt       <= '0;
                            state     <= BUSY;
                        end else begin
                            wb_valid     <= 1'b1;
                            wb_data      <= address_in;
                            wb_rd        <= rgD_index_in;
                            wb_reg_write <= control_in[CTL_RW];
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rdata_q <= al_rdata;
                        err_q   <= 1'b0;
                        state   <= DONE;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    wb_valid     <= 1'b1;
                    wb_data      <= err_q ? 32'b0 :
                                    (mem_we ? address_in : rdata_q);
                    wb_rd        <= rgD_index_in;
                    wb_reg_write <= control_in[CTL_RW] && !err_q;
                    mem_err      <= err_q;
                    cnt          <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage sitting directly downstream of the EX/M pipeline register. It consumes the registered ALU address, store data, 4-bit control and destination register index, and performs loads/stores over a req/ack data-memory handshake. While an access is outstanding it stalls upstream stages. Its registered results drive the M/WB boundary.

## Interface
- TIMEOUT, 16: maximum BUSY cycles awaiting mem_ack before aborting with error; ≥2.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  EX/M register holds a real instruction (0 = bubble)
- address_in  in  32  ALU result / effective address
- data_in  in  32  store data
- control_in  in  4  bit0 mem_read, bit1 mem_write, bit2 reg_write, bit3 byte access
- rgD_index_in  in  5  destination register index
- stall  out  1  hold EX/M and earlier stages (drives EX/M write low)
- mem_req  out  1  registered request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  32  word-aligned access address
- mem_wdata  out  32  store data, lane-replicated for byte stores
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completion, one-cycle pulse
- mem_rdata  in  32  load data, valid with mem_ack
- wb_valid  out  1  M/WB holds a result
- wb_data  out  32  load data or passed-through ALU result
- wb_rd  out  5  destination index
- wb_reg_write  out  1  register-file write enable
- mem_err  out  1  one-cycle pulse coincident with wb_valid: misaligned, illegal or timed-out access

## Operation
- Reset: state IDLE, timeout counter 0; all outputs 0.
- FSM states IDLE, BUSY, DONE.
- IDLE, bubble: wb_valid<=0. Non-memory valid op: wb_valid<=1, wb_data<=address_in, wb_rd, wb_reg_write<=control bit2; stall=0.
- IDLE, valid memory op: stall=1 (combinational); latch mem_addr/mem_we/mem_wdata/mem_be, mem_req<=1, wb_valid<=0, go BUSY.
- Illegal ops (read and write both set, or misaligned word address) issue no request: stall=0, result registered next cycle with wb_reg_write=0, mem_err=1.
- BUSY: stall=1, mem_req held, counter increments. On mem_ack: mem_req<=0, capture aligned rdata, go DONE. Counter reaching TIMEOUT-1 without ack: mem_req<=0, result data 0, error flagged, go DONE.
- DONE: stall=0, inputs ignored (EX/M still holds the same instruction); result loads M/WB (wb_valid=1 next cycle, wb_reg_write=control bit2 unless error), counter cleared, go IDLE.
- Store: wb_data=address_in. Load word: wb_data=mem_rdata. Load byte: lane address_in[1:0], zero-extended.
- Byte store: mem_be=1<<addr[1:0], mem_wdata=data_in[7:0] replicated ×4. Word: mem_be=4'hF. mem_addr[1:0] always 0.
- mem_ack outside BUSY ignored.

## Timing
- Non-memory op: 1-cycle latency, no stall.
- Memory op, ack in n-th BUSY cycle (n≥1): stall high n+1 cycles; wb_valid n+2 cycles after IDLE acceptance.
- Timeout: stall high TIMEOUT+1 cycles.
- Asynchronous reset mid-access drops mem_req immediately; memory must discard the request.

## Configuration
- MEM_STAGE_BYTE_EN defined: control bit3 honored, byte lanes and misalignment check as above.
- Undefined: bit3 ignored, all accesses word, mem_be=4'hF, address_in[1:0] ignored, no misalignment error.

## Structure
- Package mem_stage_pkg: control bit index constants, state enum (IDLE/BUSY/DONE), BE_WORD constant.
- Sub-module mem_lane_align: combinational store-lane replication/byte enables and load byte extraction; FSM, counter and M/WB registers in top.

## Test plan
- Non-memory op, address_in=32'h1234, control=4'b0100, rd=5 -> next cycle wb_valid=1, wb_data=32'h1234, wb_rd=5, stall never high.
- Load word addr 32'h100, ack after 3 BUSY cycles with rdata 32'hDEADBEEF -> stall high 4 cycles, wb_data=32'hDEADBEEF, wb_reg_write=1.
- Byte store addr 32'h103, data 32'h000000AB -> mem_be=4'b1000, mem_wdata=32'hABABABAB, mem_addr=32'h100, wb_reg_write=0.
- Byte load addr 32'h102, rdata 32'h11223344 -> wb_data=32'h00000022.
- No ack with TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, mem_err pulse with wb_valid, wb_reg_write=0.
- Reset asserted in BUSY -> mem_req, stall, wb_valid 0 immediately; after release next op completes normally.
